// File: rtl/alu3_pkg.sv
// Shared op-code definitions for the alu3 registered arithmetic/logic unit.
package alu3_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_EQ   = 2'b10;
  localparam logic [1:0] OP_DIV2 = 2'b11;

  typedef enum logic [1:0] {
    OPC_ADD  = OP_ADD,
    OPC_SUB  = OP_SUB,
    OPC_EQ   = OP_EQ,
    OPC_DIV2 = OP_DIV2
  } op_e;

endpackage : alu3_pkg

// File: rtl/alu3_core.sv
// Combinational datapath of alu3: decodes the op select and forms the
// WIDTH+1-bit next result from the two unsigned operands.
module alu3_core
  import alu3_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [1:0]       swSelect,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   result
);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;

  assign a_ext = {1'b0, a};
  assign b_ext = {1'b0, b};

  // NOTE: result gets a default before the case so no path can infer a latch.
  always_comb begin
    result = '0;
    case (op_e'(swSelect))
      OPC_ADD:  result = a_ext + b_ext;
      // The difference lies in (-2^WIDTH, 2^WIDTH), so bit WIDTH of the
      // extended subtraction is exactly the borrow.
      OPC_SUB:  result = a_ext - b_ext;
      OPC_EQ:   result = {(a == b), ~(a ^ b)};
      OPC_DIV2: result = {a[0], 1'b0, a[WIDTH-1:1]};
    endcase
  end

endmodule : alu3_core

// File: rtl/alu3.sv
// Top of alu3: the combinational core followed by the async-reset result
// register that feeds the display stage.
module alu3
  import alu3_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       swSelect,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   q
);

  logic [WIDTH:0] next_q;

  alu3_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .swSelect(swSelect),
    .a       (a),
    .b       (b),
    .result  (next_q)
  );

  // NOTE: registered state uses non-blocking assignment; reset is in the
  // sensitivity list so q clears immediately, without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= next_q;
  end

endmodule : alu3

// File: tb/tb_alu3.sv
// Directed, table-driven bench for alu3 (WIDTH=3) with hand-computed results.
module tb_alu3;

  localparam int WIDTH = 3;

  logic             clk;
  logic             rst;
  logic [1:0]       swSelect;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   exp;
  } vec_t;

  vec_t vecs[$];

  alu3 #(
    .WIDTH(WIDTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .swSelect(swSelect),
    .a       (a),
    .b       (b),
    .q       (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH:0] act,
                       input logic [WIDTH:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [WIDTH-1:0] va,
                       input logic [WIDTH-1:0] vb);
    swSelect = op;
    a        = va;
    b        = vb;
  endtask

  initial begin
    // add
    vecs.push_back('{2'b00, 3'd3, 3'd1, 4'b0100});
    vecs.push_back('{2'b00, 3'd4, 3'd7, 4'b1011});
    vecs.push_back('{2'b00, 3'd7, 3'd7, 4'b1110});
    // subtract
    vecs.push_back('{2'b01, 3'd2, 3'd0, 4'b0010});
    vecs.push_back('{2'b01, 3'd4, 3'd1, 4'b0011});
    vecs.push_back('{2'b01, 3'd7, 3'd7, 4'b0000});
    vecs.push_back('{2'b01, 3'd0, 3'd1, 4'b1111});
    vecs.push_back('{2'b01, 3'd1, 3'd2, 4'b1111});
    // equality
    vecs.push_back('{2'b10, 3'b000, 3'b000, 4'b1111});
    vecs.push_back('{2'b10, 3'b111, 3'b110, 4'b0110});
    vecs.push_back('{2'b10, 3'b101, 3'b010, 4'b0000});
    // divide by 2 (b ignored)
    vecs.push_back('{2'b11, 3'd0, 3'b000, 4'b0000});
    vecs.push_back('{2'b11, 3'd5, 3'b000, 4'b1010});
    vecs.push_back('{2'b11, 3'd7, 3'b000, 4'b1011});
    vecs.push_back('{2'b11, 3'd5, 3'b111, 4'b1010});
    // back-to-back mix across all codes
    vecs.push_back('{2'b00, 3'd2, 3'd5, 4'b0111});
    vecs.push_back('{2'b01, 3'd3, 3'd5, 4'b1110});
    vecs.push_back('{2'b10, 3'd3, 3'd3, 4'b1111});
    vecs.push_back('{2'b11, 3'd6, 3'd1, 4'b0011});
    vecs.push_back('{2'b00, 3'd0, 3'd0, 4'b0000});
    vecs.push_back('{2'b10, 3'd4, 3'd5, 4'b0110});
    vecs.push_back('{2'b01, 3'd5, 3'd3, 4'b0010});
    vecs.push_back('{2'b11, 3'd1, 3'd7, 4'b1000});

    // Reset from time zero, before any clock edge.
    rst = 1'b1;
    drive(2'b00, 3'd0, 3'd0);
    #2;
    check("reset_initial", q, 4'b0000);

    // Release between edges: q must hold 0 until the next edge.
    #6;
    rst = 1'b0;
    #1;
    check("reset_release_hold", q, 4'b0000);
    @(posedge clk);
    #1;

    // Table: each vector is applied right after an edge and its result is
    // expected right after the following edge, with no idle cycles between.
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), q, vecs[i].exp);
    end

    // Asynchronous reset mid-cycle while q is non-zero and inputs are live.
    drive(2'b00, 3'd4, 3'd7);
    @(posedge clk);
    #1;
    check("pre_reset_value", q, 4'b1011);
    #2;
    drive(2'b00, 3'd7, 3'd7);
    rst = 1'b1;
    #1;
    check("reset_async_clear", q, 4'b0000);
    @(posedge clk);
    #1;
    check("reset_held_over_edge", q, 4'b0000);
    #2;
    rst = 1'b0;
    #1;
    check("reset_release_mid", q, 4'b0000);
    drive(2'b00, 3'd3, 3'd1);
    @(posedge clk);
    #1;
    check("post_reset_add", q, 4'b0100);

    // Input changes between edges must not reach q until the next edge.
    #2;
    drive(2'b00, 3'd7, 3'd7);
    #1;
    check("hold_between_edges", q, 4'b0100);
    @(posedge clk);
    #1;
    check("after_change_edge", q, 4'b1110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_alu3
